freq_bar_reader: RTL and testbench

- Reads squared-magnitude frequency bins out of `freq_bram` and renders them as horizontal VGA bars; it is the read side of the bin store that the SDFT capture logic writes.
- Sits between `VgaSyncGen` (pixel coordinates) and the colour outputs, on the pixel clock.
- Bins are prefetched during horizontal blanking, so a bar value never changes mid-line and the first visible pixel is already correct.
- It replaces division-based addressing with line and bar counters.

---
 rtl/freq_bar_reader_if.sv | 17 +
 rtl/freq_bar_reader.sv | 174 +++++++++++++++++
 tb/tb_freq_bar_reader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/freq_bar_reader_if.sv
`default_nettype none
// =============================================================================
// freq_bar_reader_if : freq_bram read port; reader side is master, BRAM is slave.
// Revision 1.0
// =============================================================================
interface freq_bar_reader_if #(
  parameter int bin_addr_w  = 6,
  parameter int freq_data_w = 10
);
  logic                   bram_r_en;
  logic [bin_addr_w-1:0]  bram_r_addr;
  logic [freq_data_w-1:0] bram_d_out;

  modport master (output bram_r_en, output bram_r_addr, input bram_d_out);
  modport slave  (input bram_r_en, input bram_r_addr, output bram_d_out);
endinterface
`default_nettype wire

// File: rtl/freq_bar_reader.sv
`default_nettype none
// =============================================================================
// freq_bar_reader : renders freq_bram bins as horizontal VGA bars, fetching each
// bin during hblank. Optional peak markers under FREQ_BAR_PEAK_HOLD_EN.  Rev 1.0
// =============================================================================
module freq_bar_reader #(
  parameter int freq_bins   = 64,
  parameter int bin_addr_w  = 6,
  parameter int freq_data_w = 10,
  parameter int bar_height  = 7,
  parameter int bar_gap     = 1,
  parameter int v_active    = 480,
  parameter int peak_decay  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        x_px,
  input  logic [9:0]        y_px,
  input  logic              activevideo,
  freq_bar_reader_if.master bram,
  output logic              draw_bar,
  output logic              draw_peak
);

  localparam int c_line_w = $clog2(bar_height);
  localparam int c_cmp_w  = ((freq_data_w + 1) > 10) ? (freq_data_w + 1) : 10;

  localparam logic [c_line_w-1:0]   c_line_last = c_line_w'(bar_height - 1);
  localparam logic [c_line_w-1:0]   c_line_draw = c_line_w'(bar_height - bar_gap);
  localparam logic [bin_addr_w-1:0] c_last_bin  = bin_addr_w'(freq_bins - 1);
  localparam logic [9:0]            c_v_active  = 10'(v_active);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VBLANK  = 3'd1,
    REQ     = 3'd2,
    CAPTURE = 3'd3,
    LINE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [c_line_w-1:0]    line_cnt_q, line_cnt_d;
  logic [bin_addr_w-1:0]  bar_idx_q, bar_idx_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   past_end_q, past_end_d;
  logic [freq_data_w-1:0] bar_value_q, bar_value_d;
  logic                   av_q;
  logic                   draw_bar_q, draw_bar_d;
  logic                   draw_peak_q, draw_peak_d;

  logic                   w_vblank;
  logic                   w_av_fall;
  logic                   w_in_bar;
  logic                   w_bar_hit;
  logic                   w_peak_hit;
  logic [c_cmp_w-1:0]     w_x_ext;

  assign w_vblank  = (y_px >= c_v_active);
  assign w_av_fall = av_q & ~activevideo;
  assign w_in_bar  = frame_valid_q & ~past_end_q & (line_cnt_q < c_line_draw);
  assign w_x_ext   = c_cmp_w'(x_px);
  assign w_bar_hit = (w_x_ext < c_cmp_w'(bar_value_q));

  // Read port is a pure decode of the state, so it is 0/0 straight out of reset.
  assign bram.bram_r_en   = (state_q == REQ);
  assign bram.bram_r_addr = bar_idx_q;
  assign draw_bar         = draw_bar_q;
  assign draw_peak        = draw_peak_q;

  always_comb begin
    state_d       = state_q;
    line_cnt_d    = line_cnt_q;
    bar_idx_d     = bar_idx_q;
    frame_valid_d = frame_valid_q;
    past_end_d    = past_end_q;
    bar_value_d   = bar_value_q;

    if (w_vblank) begin
      // Takes priority over a coincident activevideo falling edge.
      state_d       = VBLANK;
      line_cnt_d    = '0;
      bar_idx_d     = '0;
      frame_valid_d = 1'b1;
      past_end_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        VBLANK:  state_d = REQ;
        REQ:     state_d = CAPTURE;
        CAPTURE: begin
          bar_value_d = bram.bram_d_out;
          state_d     = LINE;
        end
        LINE: begin
          if (w_av_fall && !past_end_q) begin
            if (line_cnt_q == c_line_last) begin
              line_cnt_d = '0;
              if (bar_idx_q == c_last_bin) begin
                past_end_d = 1'b1;
              end else begin
                bar_idx_d = bar_idx_q + bin_addr_w'(1);
                state_d   = REQ;
              end
            end else begin
              line_cnt_d = line_cnt_q + c_line_w'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    draw_bar_d  = activevideo & w_in_bar & w_bar_hit;
    draw_peak_d = activevideo & w_in_bar & w_peak_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      line_cnt_q    <= '0;
      bar_idx_q     <= '0;
      frame_valid_q <= 1'b0;
      past_end_q    <= 1'b0;
      bar_value_q   <= '0;
      av_q          <= 1'b0;
      draw_bar_q    <= 1'b0;
      draw_peak_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_cnt_q    <= line_cnt_d;
      bar_idx_q     <= bar_idx_d;
      frame_valid_q <= frame_valid_d;
      past_end_q    <= past_end_d;
      bar_value_q   <= bar_value_d;
      av_q          <= activevideo;
      draw_bar_q    <= draw_bar_d;
      draw_peak_q   <= draw_peak_d;
    end
  end

`ifdef FREQ_BAR_PEAK_HOLD_EN
  localparam logic [freq_data_w-1:0] c_decay = freq_data_w'(peak_decay);

  logic [freq_data_w-1:0] peak_q [freq_bins];
  logic [freq_data_w-1:0] w_peak_cur;
  logic [freq_data_w-1:0] w_peak_decayed;
  logic [freq_data_w-1:0] w_peak_new;
  logic [freq_data_w:0]   w_peak_hi;

  assign w_peak_cur     = peak_q[bar_idx_q];
  assign w_peak_decayed = (w_peak_cur >= c_decay) ? (w_peak_cur - c_decay) : '0;
  assign w_peak_new     = (bram.bram_d_out > w_peak_decayed) ? bram.bram_d_out : w_peak_decayed;
  // One bit wider so a full-scale peak still gets a two-pixel marker.
  assign w_peak_hi      = {1'b0, w_peak_cur} + (freq_data_w + 1)'(1);
  assign w_peak_hit     = (w_x_ext >= c_cmp_w'(w_peak_cur)) && (w_x_ext <= c_cmp_w'(w_peak_hi));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < freq_bins; i++) begin
        peak_q[i] <= '0;
      end
    end else if (state_q == CAPTURE) begin
      peak_q[bar_idx_q] <= w_peak_new;
    end
  end
`else
  // peak_decay is never negative, so this is a constant 0 marker.
  assign w_peak_hit = (peak_decay < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_bar_reader.sv
`default_nettype none
// Directed bench for freq_bar_reader: shortened lines, full 480-line frames.
module tb_freq_bar_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x_px, y_px;
  logic       activevideo;
  logic       draw_bar, draw_peak;

  always #5 clk = ~clk;

  freq_bar_reader_if #(.bin_addr_w(6), .freq_data_w(10)) bif ();

  freq_bar_reader #(
    .freq_bins(64), .bin_addr_w(6), .freq_data_w(10), .bar_height(7),
    .bar_gap(1), .v_active(480), .peak_decay(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .x_px(x_px), .y_px(y_px),
    .activevideo(activevideo), .bram(bif.master),
    .draw_bar(draw_bar), .draw_peak(draw_peak)
  );

  logic [9:0] mem [64];
  always @(posedge clk) if (bif.bram_r_en) bif.bram_d_out <= mem[bif.bram_r_addr];

  int total = 0;
  int bad   = 0;

  logic [9:0]  prev_x;
  logic        prev_av;
  logic        row_bar [128];
  logic        row_peak [128];
  logic        r0_bar [128];
  logic        r0_peak [128];
  bit          line_any_bar, line_any_peak;
  int          ones_cnt [480];
  bit          any_bar [480];
  bit          any_peak [480];
  int          peak_ones0;
  int          en_cnt, exp_addr, addr_bad, en_vis, en_past, en_after_rst;
  bit          rst_seen, snap_pend;
  logic [31:0] s_bar, s_peak, s_en, s_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: sample what the previous drive produced, then drive anew.
  task automatic step(input int x, input int y, input logic av, input logic rn);
    @(negedge clk);
    if (prev_av) begin
      row_bar[prev_x[6:0]]  = draw_bar;
      row_peak[prev_x[6:0]] = draw_peak;
    end
    if (draw_bar !== 1'b0)  line_any_bar  = 1'b1;
    if (draw_peak !== 1'b0) line_any_peak = 1'b1;
    if (bif.bram_r_en === 1'b1) begin
      en_cnt++;
      if (bif.bram_r_addr !== 6'(exp_addr)) addr_bad++;
      exp_addr++;
      if (activevideo) en_vis++;
      if (y_px >= 10'd448 && y_px < 10'd480) en_past++;
      if (rst_seen) en_after_rst++;
    end
    if (snap_pend) begin
      s_bar = 32'(draw_bar); s_peak = 32'(draw_peak);
      s_en = 32'(bif.bram_r_en); s_addr = 32'(bif.bram_r_addr);
      snap_pend = 1'b0; rst_seen = 1'b1;
    end
    if (!rn) snap_pend = 1'b1;
    x_px = 10'(x); y_px = 10'(y); activevideo = av; reset_n = rn;
    prev_x = 10'(x); prev_av = av;
  endtask

  task automatic run_line(input int y, input int act, input int rst_at);
    int ones;
    line_any_bar = 1'b0; line_any_peak = 1'b0;
    for (int i = 0; i < 128; i++) begin row_bar[i] = 1'b0; row_peak[i] = 1'b0; end
    for (int x = 0; x < act; x++) step(x, y, 1'b1, (x == rst_at) ? 1'b0 : 1'b1);
    for (int c = 0; c < 4; c++) step(act + c, (y == 479) ? 480 : y + 1, 1'b0, 1'b1);
    ones = 0;
    for (int i = 0; i < 128; i++) if (row_bar[i] === 1'b1) ones++;
    ones_cnt[y] = ones; any_bar[y] = line_any_bar; any_peak[y] = line_any_peak;
    if (y == 0) begin
      peak_ones0 = 0;
      for (int i = 0; i < 128; i++) begin
        r0_bar[i] = row_bar[i]; r0_peak[i] = row_peak[i];
        if (row_peak[i] === 1'b1) peak_ones0++;
      end
    end
  endtask

  function automatic bit wide(input int y);
    return y inside {0, 6, 7, 14, 20, 200, 441, 447, 448};
  endfunction

  task automatic run_frame(input int rst_y);
    en_cnt = 0; exp_addr = 0; addr_bad = 0; en_vis = 0; en_past = 0;
    en_after_rst = 0; rst_seen = 1'b0;
    for (int v = 480; v < 482; v++)
      for (int c = 0; c < 12; c++)
        step(c, (c < 8) ? v : ((v == 481) ? 0 : v + 1), 1'b0, 1'b1);
    for (int y = 0; y < 480; y++) run_line(y, wide(y) ? 120 : 8, (y == rst_y) ? 0 : -1);
  endtask

  initial begin
    bit acc, pacc;
    reset_n = 1'b0; x_px = '0; y_px = 10'd480; activevideo = 1'b0;
    prev_x = '0; prev_av = 1'b0; snap_pend = 1'b0; rst_seen = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 10'd30;
    mem[0] = 10'd100; mem[1] = 10'd0; mem[2] = 10'd50; mem[28] = 10'd100; mem[63] = 10'd117;

    for (int i = 0; i < 3; i++) step(0, 480, 1'b0, 1'b0);
    chk("rst_draw_bar", 32'(draw_bar), 0);
    chk("rst_draw_peak", 32'(draw_peak), 0);
    chk("rst_r_en", 32'(bif.bram_r_en), 0);
    chk("rst_r_addr", 32'(bif.bram_r_addr), 0);
    step(0, 480, 1'b0, 1'b1);

    // Frame 1: full frame of bars
    run_frame(-1);
    chk("l0_x0", 32'(r0_bar[0]), 1);
    chk("l0_x99", 32'(r0_bar[99]), 1);
    chk("l0_x100", 32'(r0_bar[100]), 0);
    chk("l0_ones", ones_cnt[0], 100);
    chk("l1_narrow", ones_cnt[1], 8);
    chk("gap_l6", 32'(any_bar[6]), 0);
    chk("bar1_l7", 32'(any_bar[7]), 0);
    chk("bar2_l14", ones_cnt[14], 50);
    chk("gap_l20", 32'(any_bar[20]), 0);
    chk("bar28_l200", ones_cnt[200], 100);
    chk("bar63_l441", ones_cnt[441], 117);
    chk("gap_l447", 32'(any_bar[447]), 0);
    acc = 1'b0; pacc = 1'b0;
    for (int y = 448; y < 480; y++) acc |= any_bar[y];
    for (int y = 0; y < 480; y++) pacc |= any_peak[y];
    chk("past_end_draw", 32'(acc), 0);
    chk("en_count", en_cnt, 64);
    chk("en_addr_order", addr_bad, 0);
    chk("en_in_hblank", en_vis, 0);
    chk("en_past_end", en_past, 0);
`ifndef FREQ_BAR_PEAK_HOLD_EN
    chk("peak_off", 32'(pacc), 0);
`endif

    // Frame 2: one-clock reset at line 200
    run_frame(200);
    chk("mid_rst_bar", s_bar, 0);
    chk("mid_rst_peak", s_peak, 0);
    chk("mid_rst_en", s_en, 0);
    chk("mid_rst_addr", s_addr, 0);
    acc = 1'b0;
    for (int y = 200; y < 480; y++) acc |= any_bar[y];
    chk("after_rst_draw", 32'(acc), 0);
    chk("after_rst_en", en_after_rst, 0);
    chk("rst_frame_en", en_cnt, 29);

    // Frame 3: normal drawing again
    run_frame(-1);
    chk("f3_l0_ones", ones_cnt[0], 100);
    chk("f3_l14_ones", ones_cnt[14], 50);
    chk("f3_en_count", en_cnt, 64);

`ifdef FREQ_BAR_PEAK_HOLD_EN
    step(0, 480, 1'b0, 1'b0);
    step(0, 480, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      int lo;
      mem[0] = (f == 0) ? 10'd50 : 10'd0;
      lo = 50 - 2 * f;
      run_frame(-1);
      chk($sformatf("pk_f%0d_cnt", f + 1), peak_ones0, 2);
      chk($sformatf("pk_f%0d_pos", f + 1), {30'd0, r0_peak[lo], r0_peak[lo + 1]}, 3);
      chk($sformatf("pk_f%0d_bar", f + 1), ones_cnt[0], (f == 0) ? 50 : 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
